registro_fifo: RTL and testbench

- Parametrised successor to the team's single-code enable register.
- Buffers up to DEPTH codes of WIDTH bits, for example keyboard or scan codes arriving from a decoder, so a slower consumer can drain them in order.
- Keeps a "last accepted code" holding output, equivalent to the old single register, for existing consumers.
- Sits between the code decoder (producer) and the control/display logic (consumer).

---
 rtl/registro_fifo_if.sv | 25 ++
 rtl/registro_fifo.sv | 65 ++++++
 tb/tb_registro_fifo.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/registro_fifo_if.sv
// registro_fifo_if: producer/consumer bundle for the code buffer.
interface registro_fifo_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int CW = $clog2(DEPTH + 1);
   logic             clear;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             empty;
   logic             full;
   logic [CW-1:0]    count;
   logic             overflow;
   logic [WIDTH-1:0] last_code;
   modport master (
      output clear, wr_en, wr_data, rd_en,
      input  rd_data, empty, full, count, overflow, last_code
   );
   modport slave (
      input  clear, wr_en, wr_data, rd_en,
      output rd_data, empty, full, count, overflow, last_code
   );
endinterface

// File: rtl/registro_fifo.sv
// registro_fifo: first-word-fall-through code buffer that also holds the last accepted code.
module registro_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int OVERWRITE = 0
) (
   input logic            clk,
   input logic            reset,
   registro_fifo_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam bit OW = OVERWRITE != 0;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [WIDTH-1:0] last_code_q, last_code_d;
   logic             full, empty, hit_full, wr_ok, rd_ok;
   always_comb begin
      full        = count_q == CW'(DEPTH);
      empty       = count_q == '0;
      hit_full    = bus.wr_en && full && !bus.rd_en;
      wr_ok       = bus.wr_en && (!hit_full || OW);
      // in overwrite mode a write into a full buffer retires the oldest entry
      rd_ok       = (bus.rd_en && !empty) || (hit_full && OW);
      wr_ptr_d    = wr_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d    = rd_ok ? rd_ptr_q + PW'(1) : rd_ptr_q;
      count_d     = (wr_ok && !rd_ok) ? count_q + CW'(1) :
                    (!wr_ok && rd_ok) ? count_q - CW'(1) : count_q;
      overflow_d  = overflow_q || hit_full;
      last_code_d = wr_ok ? bus.wr_data : last_code_q;
      if (bus.clear) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         last_code_d = '0;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         last_code_q <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         last_code_q <= last_code_d;
      end
   end
   always_ff @(posedge clk) begin
      if (wr_ok && !bus.clear) mem_q[wr_ptr_q] <= bus.wr_data;
   end
   assign bus.rd_data   = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.empty     = empty;
   assign bus.full      = full;
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;
   assign bus.last_code = last_code_q;
endmodule

// File: tb/tb_registro_fifo.sv
// tb_registro_fifo: drop and overwrite variants driven in lockstep against queue models.
module tb_registro_fifo;
   localparam int DEPTH = 4;
   typedef logic [7:0] byte_q_t [$];
   typedef struct {
      logic       clr, we;
      logic [7:0] wd;
      logic       re;
      int         cnt;
      logic [7:0] rd, last;
      logic       ovf;
   } vec_t;
   logic clk = 0, reset = 0;
   int   n_chk = 0, n_fail = 0;
   byte_q_t    q0, q1;
   logic       ovf0, ovf1;
   logic [7:0] last0, last1;
   vec_t       tbl [$];
   registro_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) b0 ();
   registro_fifo_if #(.WIDTH(8), .DEPTH(DEPTH)) b1 ();
   registro_fifo #(.WIDTH(8), .DEPTH(DEPTH), .OVERWRITE(0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
   registro_fifo #(.WIDTH(8), .DEPTH(DEPTH), .OVERWRITE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));
   always #5 clk = ~clk;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   task automatic upd(input bit ow, input logic clr, we, input logic [7:0] wd, input logic re,
                      inout byte_q_t q, inout logic ovf, inout logic [7:0] last);
      if (clr) begin
         q = {};
         ovf = 0;
         last = 0;
      end else if (we && q.size() == DEPTH && !re) begin
         ovf = 1;
         if (ow) begin
            void'(q.pop_front());
            q.push_back(wd);
            last = wd;
         end
      end else begin
         if (re && q.size() > 0) void'(q.pop_front());
         if (we) begin
            q.push_back(wd);
            last = wd;
         end
      end
   endtask
   task automatic cmp_models();
      chk("cnt0", 32'(b0.count), q0.size());
      chk("empty0", b0.empty, q0.size() == 0);
      chk("full0", b0.full, q0.size() == DEPTH);
      chk("rd0", b0.rd_data, q0.size() ? q0[0] : 8'h00);
      chk("ovf0", b0.overflow, ovf0);
      chk("last0", b0.last_code, last0);
      chk("cnt1", 32'(b1.count), q1.size());
      chk("empty1", b1.empty, q1.size() == 0);
      chk("full1", b1.full, q1.size() == DEPTH);
      chk("rd1", b1.rd_data, q1.size() ? q1[0] : 8'h00);
      chk("ovf1", b1.overflow, ovf1);
      chk("last1", b1.last_code, last1);
   endtask
   task automatic step(input logic clr, we, input logic [7:0] wd, input logic re);
      b0.clear = clr; b0.wr_en = we; b0.wr_data = wd; b0.rd_en = re;
      b1.clear = clr; b1.wr_en = we; b1.wr_data = wd; b1.rd_en = re;
      @(posedge clk);
      upd(0, clr, we, wd, re, q0, ovf0, last0);
      upd(1, clr, we, wd, re, q1, ovf1, last1);
      #1;
      cmp_models();
   endtask
   task automatic add(input logic clr, we, input logic [7:0] wd, input logic re,
                      input int cnt, input logic [7:0] rd, last, input logic ovf);
      vec_t v;
      v.clr = clr; v.we = we; v.wd = wd; v.re = re;
      v.cnt = cnt; v.rd = rd; v.last = last; v.ovf = ovf;
      tbl.push_back(v);
   endtask
   initial begin
      logic [7:0] ow_exp [4];
      b0.clear = 0; b0.wr_en = 1; b0.wr_data = 8'hAA; b0.rd_en = 0;
      b1.clear = 0; b1.wr_en = 1; b1.wr_data = 8'hAA; b1.rd_en = 0;
      q0 = {}; q1 = {}; ovf0 = 0; ovf1 = 0; last0 = 0; last1 = 0;
      repeat (3) @(posedge clk);
      #2 reset = 1;
      b0.wr_en = 0; b1.wr_en = 0;
      #1;
      chk("rst_cnt", 32'(b0.count), 0);
      chk("rst_empty", b0.empty, 1);
      chk("rst_full", b0.full, 0);
      chk("rst_rd", b0.rd_data, 0);
      chk("rst_last", b0.last_code, 0);
      chk("rst_ovf", b0.overflow, 0);
      chk("rst_last1", b1.last_code, 0);
      @(negedge clk);
      // expectations are for the drop-on-full instance
      add(0,1,8'h1C,0, 1,8'h1C,8'h1C,0);
      add(0,1,8'h32,0, 2,8'h1C,8'h32,0);
      add(0,1,8'h21,0, 3,8'h1C,8'h21,0);
      add(0,1,8'h23,0, 4,8'h1C,8'h23,0);
      add(0,0,8'h00,1, 3,8'h32,8'h23,0);
      add(0,0,8'h00,1, 2,8'h21,8'h23,0);
      add(0,0,8'h00,1, 1,8'h23,8'h23,0);
      add(0,0,8'h00,1, 0,8'h00,8'h23,0);
      add(0,0,8'h00,1, 0,8'h00,8'h23,0);
      add(0,1,8'h55,1, 1,8'h55,8'h55,0);
      add(0,0,8'h00,1, 0,8'h00,8'h55,0);
      add(0,1,8'h01,0, 1,8'h01,8'h01,0);
      add(0,1,8'h02,0, 2,8'h01,8'h02,0);
      add(0,1,8'h03,0, 3,8'h01,8'h03,0);
      add(0,1,8'h04,0, 4,8'h01,8'h04,0);
      add(0,1,8'h05,0, 4,8'h01,8'h04,1);
      add(0,0,8'h00,1, 3,8'h02,8'h04,1);
      add(0,0,8'h00,1, 2,8'h03,8'h04,1);
      add(0,0,8'h00,1, 1,8'h04,8'h04,1);
      add(0,0,8'h00,1, 0,8'h00,8'h04,1);
      add(1,0,8'h00,0, 0,8'h00,8'h00,0);
      add(0,1,8'h01,0, 1,8'h01,8'h01,0);
      add(0,1,8'h02,0, 2,8'h01,8'h02,0);
      add(0,1,8'h03,0, 3,8'h01,8'h03,0);
      add(0,1,8'h04,0, 4,8'h01,8'h04,0);
      add(0,1,8'h77,1, 4,8'h02,8'h77,0);
      add(0,0,8'h00,1, 3,8'h03,8'h77,0);
      add(0,0,8'h00,1, 2,8'h04,8'h77,0);
      add(0,0,8'h00,1, 1,8'h77,8'h77,0);
      add(0,0,8'h00,1, 0,8'h00,8'h77,0);
      foreach (tbl[i]) begin
         step(tbl[i].clr, tbl[i].we, tbl[i].wd, tbl[i].re);
         chk($sformatf("tbl%0d_cnt", i), 32'(b0.count), tbl[i].cnt);
         chk($sformatf("tbl%0d_rd", i), b0.rd_data, tbl[i].rd);
         chk($sformatf("tbl%0d_last", i), b0.last_code, tbl[i].last);
         chk($sformatf("tbl%0d_ovf", i), b0.overflow, tbl[i].ovf);
      end
      step(1, 0, 0, 0);
      for (int i = 1; i <= 5; i++) step(0, 1, 8'(i), 0);
      chk("ow_ovf", b1.overflow, 1);
      chk("ow_cnt", 32'(b1.count), 4);
      chk("ow_last", b1.last_code, 8'h05);
      chk("drop_last", b0.last_code, 8'h04);
      ow_exp[0] = 8'h02; ow_exp[1] = 8'h03; ow_exp[2] = 8'h04; ow_exp[3] = 8'h05;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ow_drain%0d", i), b1.rd_data, ow_exp[i]);
         step(0, 0, 0, 1);
      end
      chk("ow_empty", b1.empty, 1);
      step(1, 0, 0, 0);
      step(0, 1, 8'h40, 0);
      step(0, 1, 8'h41, 0);
      for (int i = 2; i < 10; i++) step(0, 1, 8'h40 + 8'(i), 1);
      chk("wrap_head", b0.rd_data, 8'h48);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      for (int i = 0; i < 5; i++) step(0, 1, 8'h60 + 8'(i), 0);
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      chk("pre_clr_cnt", 32'(b0.count), 2);
      chk("pre_clr_ovf", b0.overflow, 1);
      step(1, 1, 8'hEE, 0);
      chk("clr_cnt", 32'(b0.count), 0);
      chk("clr_ovf", b0.overflow, 0);
      chk("clr_last", b0.last_code, 0);
      chk("clr_last1", b1.last_code, 0);
      step(0, 0, 0, 0);
      chk("clr_wr_ignored", b0.empty, 1);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
